trace_table: RTL and testbench

LIFO assignment-trace stack for the DPLL solver. The control FSM pushes every assignment it makes: a forced implication (F) in FIND_NEXT, or a decision (D) in DECIDE. During BACKPROP it pops entries in reverse order to undo them. A combined push+pop "replace" operation supports flipping a decision into a forced assignment in one cycle. The block also tracks stack occupancy, the current decision level and error flags.

---
 rtl/trace_table_if.sv | 41 ++++
 rtl/trace_table.sv | 149 ++++++++++++++
 tb/tb_trace_table.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/trace_table_if.sv
// Bus between the DPLL control FSM and the assignment-trace stack.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 7
`endif

interface trace_table_if #(
  parameter int VAR_W = `MAX_VARS_BITS + 1,
  parameter int CNT_W = 7
);
  logic             clear;
  logic             push;
  logic [VAR_W-1:0] push_var;
  logic             push_val;
  logic             push_type;
  logic             pop;
  logic             pop_valid;
  logic [VAR_W-1:0] pop_var;
  logic             pop_val;
  logic             pop_type;
  logic [VAR_W-1:0] top_var;
  logic             top_val;
  logic             top_type;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] dec_level;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, push, push_var, push_val, push_type, pop,
    input  pop_valid, pop_var, pop_val, pop_type, top_var, top_val, top_type,
    input  empty, full, count, dec_level, overflow, underflow
  );

  modport slave (
    input  clear, push, push_var, push_val, push_type, pop,
    output pop_valid, pop_var, pop_val, pop_type, top_var, top_val, top_type,
    output empty, full, count, dec_level, overflow, underflow
  );
endinterface

// File: rtl/trace_table.sv
// LIFO of solver assignments {var, val, type}; type 0 = decision, 1 = forced.
// Tracks occupancy, decision level and sticky misuse flags.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 7
`endif

module trace_table #(
  parameter int DEPTH = 64,
  parameter int VAR_W = `MAX_VARS_BITS + 1,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  trace_table_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [VAR_W-1:0] r_mem_var  [DEPTH];
  logic             r_mem_val  [DEPTH];
  logic             r_mem_type [DEPTH];

  logic [CNT_W-1:0] r_sp;
  logic [CNT_W-1:0] r_dec;
  logic             r_pop_valid;
  logic [VAR_W-1:0] r_pop_var;
  logic             r_pop_val;
  logic             r_pop_type;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic [AW-1:0]    w_top_idx;
  logic [VAR_W-1:0] w_top_var;
  logic             w_top_val;
  logic             w_top_type;
  logic             w_old_d;
  logic             w_new_d;

  logic [CNT_W-1:0] w_sp_nxt;
  logic [CNT_W-1:0] w_dec_nxt;
  logic             w_pv_nxt;
  logic             w_pop_ld;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;
  logic             w_we;
  logic [AW-1:0]    w_waddr;

  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == CNT_W'(DEPTH));
  // At sp == DEPTH the low bits wrap to 0, so the subtraction still lands on DEPTH-1.
  assign w_top_idx  = r_sp[AW-1:0] - AW'(1);
  assign w_top_var  = r_mem_var[w_top_idx];
  assign w_top_val  = r_mem_val[w_top_idx];
  assign w_top_type = r_mem_type[w_top_idx];
  assign w_old_d    = ~w_top_type;
  assign w_new_d    = ~bus.push_type;

  // Operation priority decode and next-state computation.
  always_comb begin
    w_sp_nxt  = r_sp;
    w_dec_nxt = r_dec;
    w_pv_nxt  = 1'b0;
    w_pop_ld  = 1'b0;
    w_ovf_nxt = r_ovf;
    w_unf_nxt = r_unf;
    w_we      = 1'b0;
    w_waddr   = r_sp[AW-1:0];
    if (bus.clear) begin
      w_sp_nxt  = '0;
      w_dec_nxt = '0;
      w_ovf_nxt = 1'b0;
      w_unf_nxt = 1'b0;
    end else if (bus.push && bus.pop && !w_empty) begin
      w_pop_ld  = 1'b1;
      w_pv_nxt  = 1'b1;
      w_we      = 1'b1;
      w_waddr   = w_top_idx;
      w_dec_nxt = r_dec + CNT_W'(w_new_d) - CNT_W'(w_old_d);
    end else if (bus.push && bus.pop) begin
      // Empty stack can never be full (DEPTH >= 2), so the push always lands.
      w_we      = 1'b1;
      w_sp_nxt  = r_sp + CNT_W'(1);
      w_dec_nxt = r_dec + CNT_W'(w_new_d);
      w_unf_nxt = 1'b1;
    end else if (bus.push && !w_full) begin
      w_we      = 1'b1;
      w_sp_nxt  = r_sp + CNT_W'(1);
      w_dec_nxt = r_dec + CNT_W'(w_new_d);
    end else if (bus.push) begin
      w_ovf_nxt = 1'b1;
    end else if (bus.pop && !w_empty) begin
      w_pop_ld  = 1'b1;
      w_pv_nxt  = 1'b1;
      w_sp_nxt  = r_sp - CNT_W'(1);
      w_dec_nxt = r_dec - CNT_W'(w_old_d);
    end else if (bus.pop) begin
      w_unf_nxt = 1'b1;
    end
  end

  // Control state and popped-entry registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sp        <= '0;
      r_dec       <= '0;
      r_pop_valid <= 1'b0;
      r_pop_var   <= '0;
      r_pop_val   <= 1'b0;
      r_pop_type  <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      r_sp        <= w_sp_nxt;
      r_dec       <= w_dec_nxt;
      r_pop_valid <= w_pv_nxt;
      r_ovf       <= w_ovf_nxt;
      r_unf       <= w_unf_nxt;
      if (w_pop_ld) begin
        r_pop_var  <= w_top_var;
        r_pop_val  <= w_top_val;
        r_pop_type <= w_top_type;
      end
    end
  end

  // Entry storage; contents are never reset, only masked by sp.
  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem_var[w_waddr]  <= bus.push_var;
      r_mem_val[w_waddr]  <= bus.push_val;
      r_mem_type[w_waddr] <= bus.push_type;
    end
  end

  assign bus.pop_valid = r_pop_valid;
  assign bus.pop_var   = r_pop_var;
  assign bus.pop_val   = r_pop_val;
  assign bus.pop_type  = r_pop_type;
  assign bus.top_var   = w_empty ? '0 : w_top_var;
  assign bus.top_val   = w_empty ? 1'b0 : w_top_val;
  assign bus.top_type  = w_empty ? 1'b0 : w_top_type;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.count     = r_sp;
  assign bus.dec_level = r_dec;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;
endmodule

// File: tb/tb_trace_table.sv
// Directed bench for trace_table: vector table plus multi-cycle sequences.
module tb_trace_table;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  trace_table_if #(.VAR_W(8), .CNT_W(7)) bus ();

  trace_table #(.DEPTH(64), .VAR_W(8), .CNT_W(7)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       clr, psh, pp;
    logic [7:0] pvar;
    logic       pval, ptyp;
    int         cnt, dec;
    logic       pv;
    logic [7:0] opvar;
    logic       opval, optyp;
    logic [7:0] tvar;
    logic       tval, ttyp;
    logic       emp, ful, ovf, unf;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic p, input logic q,
                       input logic [7:0] v, input logic vl, input logic t);
    bus.clear = c; bus.push = p; bus.pop = q;
    bus.push_var = v; bus.push_val = vl; bus.push_type = t;
  endtask

  task automatic step(input logic c, input logic p, input logic q,
                      input logic [7:0] v, input logic vl, input logic t);
    drive(c, p, q, v, vl, t);
    @(posedge clock);
    #1;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    vt[0]  = '{0,1,0,8'd5,1,0, 1,1, 0,8'd0,0,0, 8'd5,1,0, 0,0,0,0};
    vt[1]  = '{0,1,0,8'd9,0,1, 2,1, 0,8'd0,0,0, 8'd9,0,1, 0,0,0,0};
    vt[2]  = '{0,1,0,8'd3,1,0, 3,2, 0,8'd0,0,0, 8'd3,1,0, 0,0,0,0};
    vt[3]  = '{0,0,1,8'd0,0,0, 2,1, 1,8'd3,1,0, 8'd9,0,1, 0,0,0,0};
    vt[4]  = '{0,0,1,8'd0,0,0, 1,1, 1,8'd9,0,1, 8'd5,1,0, 0,0,0,0};
    vt[5]  = '{0,0,1,8'd0,0,0, 0,0, 1,8'd5,1,0, 8'd0,0,0, 1,0,0,0};
    vt[6]  = '{0,0,1,8'd0,0,0, 0,0, 0,8'd5,1,0, 8'd0,0,0, 1,0,0,1};
    vt[7]  = '{1,0,0,8'd0,0,0, 0,0, 0,8'd5,1,0, 8'd0,0,0, 1,0,0,0};
    vt[8]  = '{0,1,0,8'd7,0,0, 1,1, 0,8'd5,1,0, 8'd7,0,0, 0,0,0,0};
    vt[9]  = '{0,1,1,8'd7,1,1, 1,0, 1,8'd7,0,0, 8'd7,1,1, 0,0,0,0};
    vt[10] = '{0,0,0,8'd0,0,0, 1,0, 0,8'd7,0,0, 8'd7,1,1, 0,0,0,0};
    vt[11] = '{0,0,1,8'd0,0,0, 0,0, 1,8'd7,1,1, 8'd0,0,0, 1,0,0,0};
    vt[12] = '{0,1,1,8'd2,1,0, 1,1, 0,8'd7,1,1, 8'd2,1,0, 0,0,0,1};
    vt[13] = '{1,0,0,8'd0,0,0, 0,0, 0,8'd7,1,1, 8'd0,0,0, 1,0,0,0};

    drive(0, 0, 0, 0, 0, 0);
    #12 reset_n = 1'b1;
    #1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_pv", 32'(bus.pop_valid), 0);
    chk("rst_pop_var", 32'(bus.pop_var), 0);
    chk("rst_top_var", 32'(bus.top_var), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_unf", 32'(bus.underflow), 0);

    for (int i = 0; i < 14; i++) begin
      step(vt[i].clr, vt[i].psh, vt[i].pp, vt[i].pvar, vt[i].pval, vt[i].ptyp);
      chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(vt[i].cnt));
      chk($sformatf("v%0d_dec", i), 32'(bus.dec_level), 32'(vt[i].dec));
      chk($sformatf("v%0d_pv", i), 32'(bus.pop_valid), 32'(vt[i].pv));
      chk($sformatf("v%0d_pop_var", i), 32'(bus.pop_var), 32'(vt[i].opvar));
      chk($sformatf("v%0d_pop_val", i), 32'(bus.pop_val), 32'(vt[i].opval));
      chk($sformatf("v%0d_pop_type", i), 32'(bus.pop_type), 32'(vt[i].optyp));
      chk($sformatf("v%0d_top_var", i), 32'(bus.top_var), 32'(vt[i].tvar));
      chk($sformatf("v%0d_top_val", i), 32'(bus.top_val), 32'(vt[i].tval));
      chk($sformatf("v%0d_top_type", i), 32'(bus.top_type), 32'(vt[i].ttyp));
      chk($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(vt[i].emp));
      chk($sformatf("v%0d_full", i), 32'(bus.full), 32'(vt[i].ful));
      chk($sformatf("v%0d_ovf", i), 32'(bus.overflow), 32'(vt[i].ovf));
      chk($sformatf("v%0d_unf", i), 32'(bus.underflow), 32'(vt[i].unf));
    end

    // Fill to capacity: even indices are decisions, odd are forced.
    for (int i = 0; i < 64; i++) begin
      logic [7:0] v;
      v = 8'(i);
      step(0, 1, 0, v, v[0], v[0]);
    end
    chk("fill_count", 32'(bus.count), 64);
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_dec", 32'(bus.dec_level), 32);
    chk("fill_top", 32'(bus.top_var), 63);
    step(0, 1, 0, 8'd99, 0, 0);
    chk("ovf_count", 32'(bus.count), 64);
    chk("ovf_flag", 32'(bus.overflow), 1);
    chk("ovf_top", 32'(bus.top_var), 63);
    chk("ovf_dec", 32'(bus.dec_level), 32);
    step(1, 0, 0, 0, 0, 0);
    chk("clr_ovf", 32'(bus.overflow), 0);
    chk("clr_count", 32'(bus.count), 0);

    // Ten forced entries, pop held for twelve cycles.
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'(10 + i), 1, 1);
    pulses = 0;
    drive(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clock);
      #1;
      if (bus.pop_valid) pulses++;
      chk($sformatf("hold%0d_pv", k), 32'(bus.pop_valid), (k < 10) ? 1 : 0);
      if (k < 10) chk($sformatf("hold%0d_var", k), 32'(bus.pop_var), 32'(19 - k));
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("hold_pulses", 32'(pulses), 10);
    chk("hold_unf", 32'(bus.underflow), 1);
    chk("hold_empty", 32'(bus.empty), 1);

    // Async reset between edges with a pop in flight.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(40 + i), 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("pre_rst_pv", 32'(bus.pop_valid), 1);
    chk("pre_rst_count", 32'(bus.count), 4);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_empty", 32'(bus.empty), 1);
    chk("arst_pv", 32'(bus.pop_valid), 0);
    chk("arst_dec", 32'(bus.dec_level), 0);
    #2 reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    chk("post_rst_count", 32'(bus.count), 0);
    chk("post_rst_top", 32'(bus.top_var), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
